// File: rtl/rs_fu_scheduler.sv
// Reservation-station / functional-unit scheduler: FU busy tracking, RS occupancy
// and availability-aware ALU steering. Optional stall counter under SCHED_PERF_EN.
module rs_fu_scheduler #(
  parameter int DEPTH   = 64,
  parameter int ALU_LAT = 2,
  parameter int CW      = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_valid_i,
  input  logic          disp_is_mem_i,
  output logic          disp_ready_o,
  output logic [1:0]    disp_fu_o,
  input  logic [2:0]    issue_valid_i,
  input  logic          mem_done_i,
  output logic [2:0]    fu_free_o,
  output logic [2:0]    fu_done_o,
  output logic [CW-1:0] rs_count_o,
  output logic          err_o,
  output logic [31:0]   stall_cnt_o
);

  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [0:0]    ST_IDLE    = 1'b0;
  localparam logic [0:0]    ST_BUSY    = 1'b1;
  localparam logic [LW-1:0] CNT_RELOAD = LW'(ALU_LAT - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  logic [0:0]    alu_st_q  [2];
  logic [0:0]    alu_st_d  [2];
  logic [LW-1:0] alu_cnt_q [2];
  logic [LW-1:0] alu_cnt_d [2];
  logic [0:0]    mem_st_q, mem_st_d;
  logic          alu_sel_q, alu_sel_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [2:0]    free_int, done_int, acc_issue;
  logic          acc_disp;
  logic [1:0]    n_pop;
  logic [CW:0]   sum_disp;
  logic          pref, chosen, free_pref, free_alt;

  // Availability and completion, straight from current state.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      free_int[i] = (alu_st_q[i] == ST_IDLE) || (alu_cnt_q[i] == '0);
      done_int[i] = (alu_st_q[i] == ST_BUSY) && (alu_cnt_q[i] == '0);
    end
    free_int[2] = (mem_st_q == ST_IDLE) || mem_done_i;
    done_int[2] = (mem_st_q == ST_BUSY) && mem_done_i;
    acc_issue   = issue_valid_i & free_int;
  end

  // In-flight state is still visible while rst_n is low, so outputs are forced here.
  assign fu_free_o    = rst_n ? free_int : 3'b111;
  assign fu_done_o    = rst_n ? done_int : 3'b000;
  assign disp_ready_o = !rst_n || (count_q < DEPTH_C);
  assign rs_count_o   = count_q;
  assign err_o        = err_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      alu_st_d[i]  = alu_st_q[i];
      alu_cnt_d[i] = alu_cnt_q[i];
      if (acc_issue[i]) begin
        alu_st_d[i]  = ST_BUSY;
        alu_cnt_d[i] = CNT_RELOAD;
      end else if (done_int[i]) begin
        alu_st_d[i]  = ST_IDLE;
      end else if (alu_st_q[i] == ST_BUSY) begin
        alu_cnt_d[i] = alu_cnt_q[i] - LW'(1);
      end
    end
    mem_st_d = mem_st_q;
    if (acc_issue[2])     mem_st_d = ST_BUSY;
    else if (done_int[2]) mem_st_d = ST_IDLE;
  end

  // Steering: keep alternating, but dodge a busy ALU when the other one is free.
  always_comb begin
    pref      = alu_sel_q;
    free_pref = pref ? fu_free_o[1] : fu_free_o[0];
    free_alt  = pref ? fu_free_o[0] : fu_free_o[1];
    chosen    = (!free_pref && free_alt) ? ~pref : pref;
    disp_fu_o = disp_is_mem_i ? 2'b10 : {1'b0, chosen};
    acc_disp  = disp_valid_i && disp_ready_o;
    alu_sel_d = (acc_disp && !disp_is_mem_i) ? ~chosen : alu_sel_q;
  end

  // Occupancy saturates at zero; an issue against an empty RS is flagged instead.
  always_comb begin
    n_pop    = 2'(acc_issue[0]) + 2'(acc_issue[1]) + 2'(acc_issue[2]);
    sum_disp = {1'b0, count_q} + (CW+1)'(acc_disp);
    count_d  = (sum_disp >= (CW+1)'(n_pop)) ? CW'(sum_disp - (CW+1)'(n_pop)) : '0;
    err_d    = err_q
             || (|(issue_valid_i & ~free_int))
             || ((|issue_valid_i) && (count_q == '0));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        alu_st_q[i]  <= ST_IDLE;
        alu_cnt_q[i] <= '0;
      end
      mem_st_q  <= ST_IDLE;
      alu_sel_q <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        alu_st_q[i]  <= alu_st_d[i];
        alu_cnt_q[i] <= alu_cnt_d[i];
      end
      mem_st_q  <= mem_st_d;
      alu_sel_q <= alu_sel_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (disp_valid_i && !disp_ready_o) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_rs_fu_scheduler.sv
// Directed bench for rs_fu_scheduler (DEPTH=4, ALU_LAT=2); completions are
// predicted into a scoreboard queue at issue time and compared every cycle.
module tb_rs_fu_scheduler;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;
  localparam int CW      = 7;
`ifdef SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_valid_i = 1'b0;
  logic          disp_is_mem_i = 1'b0;
  logic          disp_ready_o;
  logic [1:0]    disp_fu_o;
  logic [2:0]    issue_valid_i = 3'b000;
  logic          mem_done_i = 1'b0;
  logic [2:0]    fu_free_o;
  logic [2:0]    fu_done_o;
  logic [CW-1:0] rs_count_o;
  logic          err_o;
  logic [31:0]   stall_cnt_o;

  typedef struct {
    int         cyc;
    logic [2:0] mask;
  } done_t;

  done_t sb[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    stall_exp = 0;
  logic [1:0] fu_seq [4] = '{2'b00, 2'b01, 2'b00, 2'b01};

  rs_fu_scheduler #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .CW(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .disp_valid_i  (disp_valid_i),
    .disp_is_mem_i (disp_is_mem_i),
    .disp_ready_o  (disp_ready_o),
    .disp_fu_o     (disp_fu_o),
    .issue_valid_i (issue_valid_i),
    .mem_done_i    (mem_done_i),
    .fu_free_o     (fu_free_o),
    .fu_done_o     (fu_done_o),
    .rs_count_o    (rs_count_o),
    .err_o         (err_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic dm, input logic [2:0] iv, input logic md);
    disp_valid_i  = dv;
    disp_is_mem_i = dm;
    issue_valid_i = iv;
    mem_done_i    = md;
  endtask

  task automatic expect_done(input int offset, input logic [2:0] m);
    sb.push_back('{cyc + offset, m});
  endtask

  // Mid-cycle sample point: pop this cycle's predicted completions and compare.
  task automatic mid();
    logic [2:0] exp;
    @(negedge clk);
    exp = 3'b000;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        exp |= sb[k].mask;
        sb.delete(k);
      end
    end
    check("fu_done", {29'd0, fu_done_o}, {29'd0, exp});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Reset held for two cycles; outputs forced while low.
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    mid();
    check("rst_free", {29'd0, fu_free_o}, 32'h7);
    check("rst_ready", {31'd0, disp_ready_o}, 32'h1);
    adv();
    mid();
    adv();
    rst_n = 1'b1;

    mid();
    check("idle_free", {29'd0, fu_free_o}, 32'h7);
    check("idle_count", 32'(rs_count_o), 32'd0);
    check("idle_ready", {31'd0, disp_ready_o}, 32'h1);
    check("idle_err", {31'd0, err_o}, 32'h0);
    check("idle_stall", stall_cnt_o, 32'd0);
    adv();

    // Four ALU dispatches alternate, and fill the RS.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 3'b000, 1'b0);
      mid();
      check("steer_alt", {30'd0, disp_fu_o}, {30'd0, fu_seq[i]});
      adv();
    end

    // Full: dispatch refused while both ALUs issue.
    drive(1'b1, 1'b0, 3'b011, 1'b0);
    expect_done(ALU_LAT, 3'b011);
    stall_exp++;
    mid();
    check("full_ready", {31'd0, disp_ready_o}, 32'h0);
    check("full_count", 32'(rs_count_o), 32'd4);
    adv();

    drive(1'b0, 1'b0, 3'b000, 1'b0);
    mid();
    check("count_after_issue", 32'(rs_count_o), 32'd2);
    check("alu_busy_free", {29'd0, fu_free_o}, 32'h4);
    adv();

    // Completion cycle: free again, back-to-back re-issue of ALU0.
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    expect_done(ALU_LAT, 3'b001);
    mid();
    check("done_cycle_free", {29'd0, fu_free_o}, 32'h7);
    adv();

    drive(1'b0, 1'b0, 3'b000, 1'b0);
    mid();
    check("reissue_busy", {29'd0, fu_free_o}, 32'h6);
    adv();

    drive(1'b0, 1'b0, 3'b001, 1'b0);
    expect_done(ALU_LAT, 3'b001);
    mid();
    adv();

    // ALU0 busy with alu_sel=0: steer to ALU1, alu_sel returns to 0.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    mid();
    check("steer_busy_free", {29'd0, fu_free_o}, 32'h6);
    check("steer_avoid_busy", {30'd0, disp_fu_o}, 32'h1);
    adv();

    drive(1'b1, 1'b0, 3'b000, 1'b0);
    mid();
    check("steer_sel_back0", {30'd0, disp_fu_o}, 32'h0);
    adv();

    drive(1'b1, 1'b1, 3'b000, 1'b0);
    mid();
    check("steer_mem", {30'd0, disp_fu_o}, 32'h2);
    adv();

    drive(1'b1, 1'b0, 3'b000, 1'b0);
    mid();
    check("steer_after_mem", {30'd0, disp_fu_o}, 32'h1);
    adv();

    // MEM: variable latency, ten cycles without mem_done.
    drive(1'b0, 1'b0, 3'b100, 1'b0);
    mid();
    check("mem_issue_count", 32'(rs_count_o), 32'd4);
    adv();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 3'b000, 1'b0);
      mid();
      check("mem_wait_free", {29'd0, fu_free_o}, 32'h3);
      adv();
    end
    drive(1'b0, 1'b0, 3'b000, 1'b1);
    expect_done(0, 3'b100);
    mid();
    check("mem_done_free", {29'd0, fu_free_o}, 32'h7);
    adv();
    drive(1'b0, 1'b0, 3'b000, 1'b1);
    mid();
    check("mem_idle_free", {29'd0, fu_free_o}, 32'h7);
    adv();

    // Issue to a busy ALU is ignored and flags an error.
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    expect_done(ALU_LAT, 3'b001);
    mid();
    check("err_before", {31'd0, err_o}, 32'h0);
    adv();
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    mid();
    adv();
    drive(1'b0, 1'b0, 3'b010, 1'b0);
    expect_done(ALU_LAT, 3'b010);
    mid();
    check("err_busy_issue", {31'd0, err_o}, 32'h1);
    check("busy_issue_count", 32'(rs_count_o), 32'd2);
    adv();
    drive(1'b0, 1'b0, 3'b100, 1'b0);
    mid();
    adv();
    drive(1'b0, 1'b0, 3'b000, 1'b1);
    expect_done(0, 3'b100);
    mid();
    check("drained_count", 32'(rs_count_o), 32'd0);
    adv();

    // Reset with ALU0 in flight: no completion pulse survives it.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    mid();
    adv();
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    mid();
    adv();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    mid();
    check("midrst_free", {29'd0, fu_free_o}, 32'h7);
    check("midrst_ready", {31'd0, disp_ready_o}, 32'h1);
    adv();
    rst_n = 1'b1;
    stall_exp = 0;
    mid();
    check("postrst_err", {31'd0, err_o}, 32'h0);
    check("postrst_count", 32'(rs_count_o), 32'd0);
    check("postrst_free", {29'd0, fu_free_o}, 32'h7);
    check("postrst_stall", stall_cnt_o, 32'd0);
    adv();

    // Issue with an empty RS: error, count held at zero, flag sticky.
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    expect_done(ALU_LAT, 3'b001);
    mid();
    check("empty_err_before", {31'd0, err_o}, 32'h0);
    adv();
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    mid();
    check("empty_err", {31'd0, err_o}, 32'h1);
    check("empty_count", 32'(rs_count_o), 32'd0);
    adv();
    mid();
    check("err_sticky", {31'd0, err_o}, 32'h1);
    adv();

    // Fill again, then five refused dispatch cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 3'b000, 1'b0);
      mid();
      check("refill_steer", {30'd0, disp_fu_o}, {30'd0, fu_seq[i]});
      adv();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 3'b000, 1'b0);
      stall_exp++;
      mid();
      check("stall_ready", {31'd0, disp_ready_o}, 32'h0);
      adv();
    end
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    mid();
    check("stall_count", stall_cnt_o, PERF ? 32'(stall_exp) : 32'd0);
    check("stall_rs_count", 32'(rs_count_o), 32'd4);
    adv();

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
